// File: rtl/sbus_pkg.sv
// Shared types and elaboration helpers for the simple-bus burst follower.
package sbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RWAIT,
        RDATA,
        WDATA
    } sbus_state_e;

    function automatic int unsigned sbus_addr_w(input int unsigned bus_w,
                                                input int unsigned addr_beats);
        return bus_w * addr_beats;
    endfunction

    function automatic bit sbus_params_ok(input int unsigned bus_w,
                                          input int unsigned addr_beats,
                                          input int unsigned mem_aw);
        return (addr_beats >= 1) && (mem_aw <= sbus_addr_w(bus_w, addr_beats));
    endfunction

endpackage

// File: rtl/sbus_mem_array.sv
// Single-port RAM: synchronous write, read data follows the address in the same cycle.
module sbus_mem_array #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_c_o
);

    // Contents are not reset; they start at zero and survive bus resets.
    logic [DW-1:0] mem_q [2**AW] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/sbus_burst_follower.sv
// Memory-side simple-bus follower: MSB-first multiplexed address, then a read
// or write burst with optional read wait states and wrapping addresses.
module sbus_burst_follower
    import sbus_pkg::*;
#(
    parameter int unsigned BUS_W      = 8,
    parameter int unsigned ADDR_BEATS = 2,
    parameter int unsigned MEM_AW     = 16,
    parameter int unsigned LEN_W      = 2,
    parameter int unsigned READ_WAIT  = 0
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             start,
    input  logic             read,
    input  logic [BUS_W-1:0] address,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [BUS_W-1:0] data_in,
    output logic [BUS_W-1:0] data_out,
    output logic             data_oe,
    input  logic             dv_in,
    output logic             dv_out,
    output logic             dv_oe,
    output logic             busy
);

    localparam int unsigned ADDR_W  = sbus_addr_w(BUS_W, ADDR_BEATS);
    localparam int unsigned ABEAT_W = (ADDR_BEATS > 1) ? $clog2(ADDR_BEATS) : 1;
    localparam int unsigned WAIT_W  = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    if (!sbus_params_ok(BUS_W, ADDR_BEATS, MEM_AW)) begin : g_bad_params
        $error("sbus_burst_follower: need ADDR_BEATS >= 1 and MEM_AW <= BUS_W*ADDR_BEATS");
    end

    sbus_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [ABEAT_W-1:0] abeat_q, abeat_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [BUS_W-1:0]   dout_q, dout_d;
    logic               doe_q, doe_d;
    logic               dvo_q, dvo_d;
    logic               dvoe_q, dvoe_d;
    logic               busy_q, busy_d;
    logic               last_abeat;

    logic               mem_we_c;
    logic [MEM_AW-1:0]  mem_addr_c;
    logic [BUS_W-1:0]   mem_rdata_c;

    // Address path kept apart so the RAM read address never depends on RAM data.
    always_comb begin
        addr_d = addr_q;
        if ((state_q == IDLE && start) || state_q == ADDR) begin
            addr_d = ADDR_W'({addr_q, address});
        end else if ((state_q == RDATA && cnt_q != len_q) || (state_q == WDATA && dv_in)) begin
            addr_d = addr_q + 1'b1;
        end
    end

    assign mem_we_c   = (state_q == WDATA) && dv_in;
    // Writes use the current beat address; reads look ahead so the registered
    // data_out lines up with the beat it belongs to.
    assign mem_addr_c = mem_we_c ? addr_q[MEM_AW-1:0] : addr_d[MEM_AW-1:0];

    sbus_mem_array #(
        .AW (MEM_AW),
        .DW (BUS_W)
    ) u_mem (
        .clk       (clock),
        .we_i      (mem_we_c),
        .addr_i    (mem_addr_c),
        .wdata_i   (data_in),
        .rdata_c_o (mem_rdata_c)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        abeat_d    = abeat_q;
        wait_d     = wait_q;
        dout_d     = '0;
        doe_d      = 1'b0;
        dvo_d      = 1'b0;
        dvoe_d     = 1'b0;
        last_abeat = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = burst_len;
                    abeat_d = ABEAT_W'(1);
                    if (ADDR_BEATS == 1) begin
                        last_abeat = 1'b1;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                abeat_d = abeat_q + 1'b1;
                if (abeat_q == ABEAT_W'(ADDR_BEATS - 1)) begin
                    last_abeat = 1'b1;
                end
            end
            RWAIT: begin
                dvoe_d = 1'b1;
                if (wait_q == WAIT_W'(READ_WAIT - 1)) begin
                    state_d = RDATA;
                    dvo_d   = 1'b1;
                    doe_d   = 1'b1;
                    dout_d  = mem_rdata_c;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RDATA: begin
                if (cnt_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    dvoe_d = 1'b1;
                    dvo_d  = 1'b1;
                    doe_d  = 1'b1;
                    dout_d = mem_rdata_c;
                end
            end
            WDATA: begin
                if (dv_in) begin
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Direction is decided on the final address beat.
        if (last_abeat) begin
            cnt_d  = '0;
            wait_d = '0;
            if (!read) begin
                state_d = WDATA;
            end else if (READ_WAIT > 0) begin
                state_d = RWAIT;
                dvoe_d  = 1'b1;
            end else begin
                state_d = RDATA;
                dvoe_d  = 1'b1;
                dvo_d   = 1'b1;
                doe_d   = 1'b1;
                dout_d  = mem_rdata_c;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            abeat_q <= '0;
            wait_q  <= '0;
            dout_q  <= '0;
            doe_q   <= 1'b0;
            dvo_q   <= 1'b0;
            dvoe_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            abeat_q <= abeat_d;
            wait_q  <= wait_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            dvo_q   <= dvo_d;
            dvoe_q  <= dvoe_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out = dout_q;
    assign data_oe  = doe_q;
    assign dv_out   = dvo_q;
    assign dv_oe    = dvoe_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sbus_burst_follower.sv
// Scoreboard bench: A (defaults), B (READ_WAIT=3) share stimulus; C is the
// single-beat 16-bit variant with a 10-bit memory.
module tb_sbus_burst_follower;

    localparam int unsigned RW_B = 3;

    typedef struct {
        logic [15:0] d;
        int unsigned cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetN;
    logic        start_ab, start_c, read, dv_in;
    logic [15:0] addr_bus, din_bus;
    logic [1:0]  blen;

    logic [7:0]  dout_a, dout_b;
    logic [15:0] dout_cc;
    logic        doe_a, dvo_a, dvoe_a, busy_a;
    logic        doe_b, dvo_b, dvoe_b, busy_b;
    logic        doe_c, dvo_c, dvoe_c, busy_c;

    logic [15:0] dout [3];
    logic        doe [3], dvo [3], dvoe [3], bsy [3];

    int unsigned cyc = 0;
    int unsigned c0;
    int          vectors = 0;
    int          miscompares = 0;

    exp_t        expq [3][$];
    logic [15:0] mdl [int unsigned];
    bit          dv_pat [$];
    logic [15:0] wq [$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    sbus_burst_follower #(.BUS_W(8), .ADDR_BEATS(2), .MEM_AW(16), .LEN_W(2), .READ_WAIT(0)) u_a (
        .clock(clock), .resetN(resetN), .start(start_ab), .read(read), .address(addr_bus[7:0]),
        .burst_len(blen), .data_in(din_bus[7:0]), .data_out(dout_a), .data_oe(doe_a),
        .dv_in(dv_in), .dv_out(dvo_a), .dv_oe(dvoe_a), .busy(busy_a));

    sbus_burst_follower #(.BUS_W(8), .ADDR_BEATS(2), .MEM_AW(16), .LEN_W(2), .READ_WAIT(RW_B)) u_b (
        .clock(clock), .resetN(resetN), .start(start_ab), .read(read), .address(addr_bus[7:0]),
        .burst_len(blen), .data_in(din_bus[7:0]), .data_out(dout_b), .data_oe(doe_b),
        .dv_in(dv_in), .dv_out(dvo_b), .dv_oe(dvoe_b), .busy(busy_b));

    sbus_burst_follower #(.BUS_W(16), .ADDR_BEATS(1), .MEM_AW(10), .LEN_W(2), .READ_WAIT(0)) u_c (
        .clock(clock), .resetN(resetN), .start(start_c), .read(read), .address(addr_bus),
        .burst_len(blen), .data_in(din_bus), .data_out(dout_cc), .data_oe(doe_c),
        .dv_in(dv_in), .dv_out(dvo_c), .dv_oe(dvoe_c), .busy(busy_c));

    assign dout[0] = {8'h00, dout_a};
    assign dout[1] = {8'h00, dout_b};
    assign dout[2] = dout_cc;
    assign doe[0] = doe_a;   assign doe[1] = doe_b;   assign doe[2] = doe_c;
    assign dvo[0] = dvo_a;   assign dvo[1] = dvo_b;   assign dvo[2] = dvo_c;
    assign dvoe[0] = dvoe_a; assign dvoe[1] = dvoe_b; assign dvoe[2] = dvoe_c;
    assign bsy[0] = busy_a;  assign bsy[1] = busy_b;  assign bsy[2] = busy_c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, expv);
        end
    endtask

    function automatic int unsigned amask(input bit c);
        return c ? 32'h3FF : 32'hFFFF;
    endfunction

    function automatic logic [15:0] dmask(input bit c);
        return c ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic int unsigned mkey(input bit c, input int unsigned a);
        return (c ? 32'h10000 : 32'h0) + (a & amask(c));
    endfunction

    function automatic logic [15:0] mget(input bit c, input int unsigned a);
        int unsigned k = mkey(c, a);
        return mdl.exists(k) ? mdl[k] : 16'h0000;
    endfunction

    task automatic noise();
        addr_bus = 16'($urandom);
        read     = 1'($urandom);
        blen     = 2'($urandom);
        din_bus  = 16'($urandom);
    endtask

    task automatic idle_inputs();
        start_ab = 1'b0;
        start_c  = 1'b0;
        dv_in    = 1'b0;
        noise();
    endtask

    task automatic chk_busy(input bit c, input logic expv, input string nm);
        if (c) chk({nm, "_c"}, 32'(busy_c), 32'(expv));
        else begin
            chk({nm, "_a"}, 32'(busy_a), 32'(expv));
            chk({nm, "_b"}, 32'(busy_b), 32'(expv));
        end
    endtask

    // Drive the address phase; c0 marks the cycle of the final address beat.
    task automatic issue(input bit c, input int unsigned a, input bit rd, input int unsigned len);
        @(negedge clock);
        noise();
        blen = 2'(len);
        if (c) begin
            start_c = 1'b1; addr_bus = 16'(a); read = rd;
        end else begin
            start_ab = 1'b1; addr_bus = {8'h00, 8'(a >> 8)};
            @(negedge clock);
            start_ab = 1'($urandom); addr_bus = {8'h00, 8'(a)}; read = rd; blen = 2'($urandom);
        end
        c0 = cyc;
    endtask

    task automatic do_wr(input bit c, input int unsigned a, input int unsigned len);
        int unsigned cur = a & amask(c);
        int unsigned beat = 0;
        int unsigned n = 0;
        logic [15:0] w;
        issue(c, a, 1'b0, len);
        while (beat <= len && n < 200) begin
            @(negedge clock);
            noise();
            start_ab = c ? 1'b0 : 1'($urandom);
            start_c  = c ? 1'($urandom) : 1'b0;
            dv_in    = (n < dv_pat.size()) ? dv_pat[n] : ($urandom_range(3) != 0);
            chk_busy(c, 1'b1, "busy_wdata");
            chk("dv_oe_wdata", 32'(c ? dvoe_c : (dvoe_a | dvoe_b)), 32'h0);
            if (dv_in) begin
                w = ((beat < wq.size()) ? wq[beat] : 16'($urandom)) & dmask(c);
                din_bus = w;
                mdl[mkey(c, cur)] = w;
                cur = (cur + 1) & amask(c);
                beat++;
            end
            n++;
        end
        if (n >= 200) chk("write_budget", n, 0);
        @(negedge clock);
        idle_inputs();
        chk_busy(c, 1'b0, "busy_after_wr");
        dv_pat.delete();
        wq.delete();
    endtask

    task automatic do_rd(input bit c, input int unsigned a, input int unsigned len, input bit abort);
        int unsigned cur = a & amask(c);
        int unsigned done;
        logic [15:0] d;
        issue(c, a, 1'b1, len);
        for (int unsigned k = 0; k <= len; k++) begin
            d = mget(c, cur);
            if (c) expq[2].push_back('{d: d, cyc: c0 + 1 + k});
            else begin
                expq[0].push_back('{d: d, cyc: c0 + 1 + k});
                expq[1].push_back('{d: d, cyc: c0 + 1 + RW_B + k});
            end
            cur = (cur + 1) & amask(c);
        end
        done = c ? len + 2 : len + 2 + RW_B;
        for (int unsigned rel = 1; rel <= done; rel++) begin
            @(negedge clock);
            noise();
            dv_in    = 1'($urandom);
            start_ab = 1'b0;
            start_c  = (c && rel <= len + 1) ? 1'($urandom) : 1'b0;
            if (!c) begin
                if (rel <= RW_B) begin
                    chk("rwait_dv_oe_b", 32'(dvoe_b), 32'h1);
                    chk("rwait_dv_out_b", 32'(dvo_b), 32'h0);
                end
                if (rel == len + 1) chk("busy_last_beat_a", 32'(busy_a), 32'h1);
                if (rel == len + 2) chk("busy_end_a", 32'(busy_a), 32'h0);
                if (rel == done) chk("busy_end_b", 32'(busy_b), 32'h0);
            end else if (rel == done) begin
                chk("busy_end_c", 32'(busy_c), 32'h0);
            end
            if (abort && rel == 2) begin
                #2 resetN = 1'b0;
                #1;
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("rst_data_out%0d", i), 32'(dout[i]), 32'h0);
                    chk($sformatf("rst_data_oe%0d", i), 32'(doe[i]), 32'h0);
                    chk($sformatf("rst_dv_out%0d", i), 32'(dvo[i]), 32'h0);
                    chk($sformatf("rst_dv_oe%0d", i), 32'(dvoe[i]), 32'h0);
                    chk($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'h0);
                end
                expq[0].delete();
                expq[1].delete();
                @(negedge clock);
                resetN = 1'b1;
                break;
            end
        end
        idle_inputs();
    endtask

    // Monitor: every presented read beat is matched against the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (resetN) begin
            for (int i = 0; i < 3; i++) begin
                if (dvoe[i] && dvo[i]) begin
                    if (expq[i].size() == 0) begin
                        chk($sformatf("unexpected_beat%0d", i), 32'(expq[i].size()), 32'h1);
                    end else begin
                        e = expq[i].pop_front();
                        chk($sformatf("beat_data%0d", i), 32'(dout[i]), 32'(e.d));
                        chk($sformatf("beat_cycle%0d", i), cyc, e.cyc);
                    end
                end
                chk($sformatf("data_oe%0d", i), 32'(doe[i]), 32'(dvoe[i] & dvo[i]));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a, len;
        resetN = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_data_out%0d", i), 32'(dout[i]), 32'h0);
            chk($sformatf("reset_data_oe%0d", i), 32'(doe[i]), 32'h0);
            chk($sformatf("reset_dv_out%0d", i), 32'(dvo[i]), 32'h0);
            chk($sformatf("reset_dv_oe%0d", i), 32'(dvoe[i]), 32'h0);
            chk($sformatf("reset_busy%0d", i), 32'(bsy[i]), 32'h0);
        end
        resetN = 1'b1;

        wq = '{16'h00A5}; dv_pat = '{1'b1};
        do_wr(1'b0, 32'h1234, 0);
        do_rd(1'b0, 32'h1234, 0, 1'b0);

        wq = '{16'd1, 16'd2, 16'd3, 16'd4}; dv_pat = '{1'b1, 1'b1, 1'b1, 1'b1};
        do_wr(1'b0, 32'hFFFE, 3);
        do_rd(1'b0, 32'hFFFE, 3, 1'b0);
        do_rd(1'b0, 32'h0001, 0, 1'b0);

        dv_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_wr(1'b0, 32'h0100, 1);
        do_rd(1'b0, 32'h0100, 2, 1'b0);

        do_rd(1'b0, 32'hFFFE, 3, 1'b1);
        do_rd(1'b0, 32'hFFFE, 3, 1'b0);

        for (int t = 0; t < 40; t++) begin
            a   = ($urandom_range(2) == 0) ? (32'hFFFC + $urandom_range(3)) : $urandom_range(24);
            len = $urandom_range(3);
            if ($urandom_range(1) == 0) do_wr(1'b0, a, len);
            else do_rd(1'b0, a, len, 1'b0);
        end

        wq = '{16'hBEEF}; dv_pat = '{1'b1};
        do_wr(1'b1, 32'h0405, 0);
        do_rd(1'b1, 32'h0005, 0, 1'b0);
        do_rd(1'b1, 32'hFC05, 0, 1'b0);
        for (int t = 0; t < 30; t++) begin
            a = ($urandom & 32'hFC00) |
                (($urandom_range(1) == 0) ? (32'h3FC + $urandom_range(3)) : $urandom_range(12));
            len = $urandom_range(3);
            if ($urandom_range(1) == 0) do_wr(1'b1, a, len);
            else do_rd(1'b1, a, len, 1'b0);
        end

        repeat (4) @(negedge clock);
        for (int i = 0; i < 3; i++) chk($sformatf("queue_drained%0d", i), 32'(expq[i].size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sbus_burst_follower.md
Name: sbus_burst_follower

Overview:
- Parametrised memory-side follower for the simple bus, succeeding the single-beat 8-bit memory thread.
- Accepts a multiplexed address sent MSB chunk first over ADDR_BEATS cycles, then performs a read or write burst of 1..2**LEN_W beats.
- Supports programmable read wait states and incrementing addresses with wrap-around.
- Uses split in/out/oe ports; the top level resolves the tri-state data and dataValid nets.

Parameters:
- BUS_W, 8: width of the address/data bus chunk.
- ADDR_BEATS, 2: number of address beats; full address width ADDR_W = BUS_W*ADDR_BEATS.
- MEM_AW, 16: implemented memory address bits, taken from the low bits of the address; MEM_AW <= ADDR_W.
- LEN_W, 2: width of the burst-length field.
- READ_WAIT, 0: wait cycles between the last address beat and the first read data beat.

Ports:
- clock  in  1  bus clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- start  in  1  leader marks the first address beat
- read  in  1  1 = read, 0 = write; sampled on the last address beat
- address  in  BUS_W  address chunk, MSB chunk first
- burst_len  in  LEN_W  beats minus 1; sampled with start
- data_in  in  BUS_W  write data from leader
- data_out  out  BUS_W  read data
- data_oe  out  1  follower drives data
- dv_in  in  1  leader dataValid (write beats)
- dv_out  out  1  follower dataValid (read beats)
- dv_oe  out  1  follower drives dataValid
- busy  out  1  transaction in progress (state != IDLE)

Behaviour:
- Reset: state IDLE; data_out=0, data_oe=0, dv_out=0, dv_oe=0, busy=0.
  - Address, count and wait registers are cleared.
  - Memory is NOT reset; it is zero-initialised at time 0 only.
- States: IDLE, ADDR, RWAIT, RDATA, WDATA.
- IDLE:
  - start=1 captures address into the top chunk and latches burst_len.
  - If ADDR_BEATS=1, read is also sampled now and the FSM branches as for the last beat.
  - Otherwise go to ADDR.
  - start is ignored in every other state; no queuing and no abort.
- ADDR:
  - Each cycle shifts in the next chunk, toward the LSB.
  - On the last beat, read is sampled. If read=1: go to RWAIT when READ_WAIT>0, else RDATA. If read=0: go to WDATA.
- RWAIT: counts READ_WAIT cycles. dv_oe=1 and dv_out=0 throughout; data_oe=0.
- RDATA:
  - Every cycle: dv_oe=1, dv_out=1, data_oe=1, data_out=mem[addr+k] for beat k.
  - Beats are contiguous with no stalls.
  - After beat burst_len, return to IDLE; dv_oe and data_oe drop in that same next cycle.
- Read latency: beat 0 appears in the cycle after the last address beat, plus READ_WAIT cycles.
- WDATA:
  - dv_oe=0 and data_oe=0 throughout.
  - On each rising edge with dv_in=1, write data_in to mem[addr], increment addr and count.
  - dv_in=0 cycles are stalls, with no timeout.
  - After the write of beat burst_len, return to IDLE.
- Address arithmetic:
  - Only the low MEM_AW bits index memory.
  - Increment is modulo 2**MEM_AW: 0xFFFF+1 wraps to 0x0000.
  - Upper address bits are ignored.
- burst_len encoding: n means n+1 beats. With LEN_W=2, values 0..3 give 1..4 beats.
- Asynchronous reset mid-burst: immediate return to IDLE with all enables low. Memory writes already completed are retained.
- busy=1 in every state except IDLE.

Decomposition:
- Package sbus_pkg holds:
  - the state enum sbus_state_e {IDLE, ADDR, RWAIT, RDATA, WDATA};
  - the constant computing ADDR_W from BUS_W and ADDR_BEATS;
  - the parameter legality checks (MEM_AW <= ADDR_W, ADDR_BEATS >= 1).
- One sub-module, sbus_mem_array: single-port RAM, 2**MEM_AW x BUS_W, synchronous write, read data available for the current address with no added cycle.
- The FSM, counters and output drive stay in sbus_burst_follower.

Test Plan:
- Defaults, single write then read: start with address=0x12, next cycle 0x34, read=0, burst_len=0, dv_in=1, data_in=0xA5.
  - Then read 0x1234 with burst_len=0.
  - Expect: dv_out=1 and data_out=0xA5 exactly 1 cycle after the last address beat; busy returns to 0 the following cycle.
- Burst with wrap: write 4 beats (burst_len=3) at 0xFFFE with data 1,2,3,4, then read 4 beats from 0xFFFE.
  - Expect: mem[0xFFFE]=1, mem[0xFFFF]=2, mem[0x0000]=3, mem[0x0001]=4.
  - The read returns 1,2,3,4 on 4 consecutive dv_out cycles.
- READ_WAIT=3: read of 0x0001.
  - Expect: dv_oe=1 with dv_out=0 for 3 cycles, then dv_out=1 with the data.
- Write stalls: 2-beat write with dv_in pattern 1,0,0,1.
  - Expect: exactly 2 memory writes, to consecutive addresses; FSM in WDATA until the 4th cycle.
- Reset mid-read: assert resetN=0 during RDATA beat 1 of 4.
  - Expect: all outputs 0 and busy=0 immediately; a subsequent read returns the previously written data.
- ADDR_BEATS=1, BUS_W=16, MEM_AW=10:
  - Start with address=0x0405 (implemented address 0x005) and read=0 in the same cycle, then write 0xBEEF.
  - A read of 0x0005 returns 0xBEEF.
  - start pulses during the burst are ignored.
